// File: rtl/joy_dir_arbiter.sv
// joy_dir_arbiter: per-channel debounce, board rotation, SOCD cleanup and 8/4-way direction arbitration.
// Latency: outdir follows the resolved direction 1 clk later; debounce adds 2^DEB_BITS ce ticks.
// Backpressure: none; inputs are level samples, outdir/changed are always valid.
// Optional: define JOYDIR_SOCD_LAST_EN for last-input-wins resolution of opposing pairs.
module joy_dir_arbiter #(
  parameter int NUM_CH   = 2,
  parameter int DEB_BITS = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ce,
  input  logic [1:0]          mode,
  input  logic [1:0]          rotate,
  input  logic [4*NUM_CH-1:0] indir,
  output logic [4*NUM_CH-1:0] outdir,
  output logic [NUM_CH-1:0]   changed
);

  // Bit order within a channel nibble: {up, down, left, right}.
  localparam logic [DEB_BITS-1:0] CNT_MAX = '1;

  function automatic logic [3:0] pick_hi(input logic [3:0] v);
    logic [3:0] r;
    r = 4'b0000;
    if (v[3])      r = 4'b1000;
    else if (v[2]) r = 4'b0100;
    else if (v[1]) r = 4'b0010;
    else if (v[0]) r = 4'b0001;
    return r;
  endfunction

  logic [1:0] rst_sync;
  logic       rst_n_int;
  logic [3:0] cfg_q;
  logic       cfg_chg;
  logic       arb_mode;

  // Reset asserts immediately and releases two clk edges after reset_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n_int = rst_sync[1];
  assign cfg_chg   = (cfg_q != {mode, rotate});
  assign arb_mode  = (mode == 2'd1) || (mode == 2'd2);

  // Registered copy of mode/rotate; a mismatch restarts arbitration on every channel.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) cfg_q <= 4'b0000;
    else            cfg_q <= {mode, rotate};
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [3:0]               raw;
    logic [3:0]               stable;
    logic [3:0][DEB_BITS-1:0] cnt;
    logic [3:0]               rot;
    logic [3:0]               socd;
    logic [3:0]               prev_socd;
    logic [3:0]               rise;
    logic [3:0]               held_q;
    logic [3:0]               held_nx;
    logic [3:0]               out_q;
    logic [3:0]               out_nx;
    logic                     chg_q;

    assign raw = indir[4*k +: 4];

    // Per-bit debounce: adopt a new level only after it persists for a full window of ce ticks.
    always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
        stable <= 4'b0000;
        cnt    <= '0;
      end else if (ce) begin
        for (int i = 0; i < 4; i++) begin
          if (raw[i] == stable[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == CNT_MAX) begin
            stable[i] <= raw[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end

    // Board rotation of the debounced directions.
    always_comb begin
      case (rotate)
        2'd1:    rot = {stable[1], stable[0], stable[2], stable[3]};
        2'd2:    rot = {stable[0], stable[1], stable[3], stable[2]};
        2'd3:    rot = {stable[2], stable[3], stable[0], stable[1]};
        default: rot = stable;
      endcase
    end

`ifdef JOYDIR_SOCD_LAST_EN
    logic [3:0]      prev_rot;
    logic [3:0]      rot_rise;
    // Per opposing pair: 0 = no newer member, 1 = up/left newer, 2 = down/right newer.
    logic [1:0][1:0] last_q;
    logic [1:0][1:0] last_nx;

    assign rot_rise = rot & ~prev_rot;

    // Opposing pairs resolve to the member that rose most recently; a tie stays neutral.
    always_comb begin
      last_nx = last_q;
      socd    = 4'b0000;
      for (int p = 0; p < 2; p++) begin
        if (rot_rise[3-2*p] && rot_rise[2-2*p]) last_nx[p] = 2'd0;
        else if (rot_rise[3-2*p])               last_nx[p] = 2'd1;
        else if (rot_rise[2-2*p])               last_nx[p] = 2'd2;
        socd[3-2*p] = rot[3-2*p] & (~rot[2-2*p] | (last_nx[p] == 2'd1));
        socd[2-2*p] = rot[2-2*p] & (~rot[3-2*p] | (last_nx[p] == 2'd2));
      end
    end

    // Pair history; a mode/rotate change forgets it so the new mapping starts clean.
    always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
        prev_rot <= 4'b0000;
        last_q   <= '0;
      end else if (cfg_chg) begin
        prev_rot <= 4'b0000;
        last_q   <= '0;
      end else begin
        prev_rot <= rot;
        last_q   <= last_nx;
      end
    end
`else
    assign socd = {rot[3] & ~rot[2], rot[2] & ~rot[3], rot[1] & ~rot[0], rot[0] & ~rot[1]};
`endif

    assign rise = socd & ~prev_socd;

    // Next held direction and output; during a config-change cycle arbitrated modes hold outdir
    // so no transient zero appears before the recompute on the following cycle.
    always_comb begin
      held_nx = 4'b0000;
      case (mode)
        2'd1: begin
          if (rise != 4'b0000)                held_nx = pick_hi(rise);
          else if ((held_q & socd) != 4'b0000) held_nx = held_q;
          else                                 held_nx = pick_hi(socd);
        end
        2'd2: begin
          if ((held_q & socd) != 4'b0000) held_nx = held_q;
          else                             held_nx = pick_hi(socd);
        end
        default: held_nx = 4'b0000;
      endcase
      out_nx = arb_mode ? held_nx : socd;
      if (cfg_chg) begin
        held_nx = 4'b0000;
        if (arb_mode) out_nx = out_q;
      end
    end

    // Output register, change strobe, held direction and edge history.
    always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
        out_q     <= 4'b0000;
        chg_q     <= 1'b0;
        held_q    <= 4'b0000;
        prev_socd <= 4'b0000;
      end else begin
        out_q     <= out_nx;
        chg_q     <= (out_nx != out_q);
        held_q    <= held_nx;
        prev_socd <= cfg_chg ? 4'b0000 : socd;
      end
    end

    assign outdir[4*k +: 4] = out_q;
    assign changed[k]       = chg_q;
  end

endmodule

// File: doc/joy_dir_arbiter.md
Name: joy_dir_arbiter

Overview:
- Multi-channel joystick direction conditioner that supersedes the single-channel 4-way filter.
- Per channel: debounce raw direction bits, apply a board rotation, resolve opposing inputs (SOCD), then arbitrate to 8-way, 4-way last-pressed or 4-way first-held output.
- Sits between the player input merge (keyboard/joystick OR) and the core's active-high direction inputs.
- Mode and rotation are global; all per-channel state is independent.

Parameters:
- NUM_CH, 2, number of player channels (1..4).
- DEB_BITS, 2, debounce counter width (1..8); a change must persist for 2^DEB_BITS consecutive ce ticks.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- ce  input  1  debounce sample enable; arbitration runs every clk
- mode  input  2  0/3 = 8-way passthrough, 1 = 4-way last-pressed, 2 = 4-way first-held
- rotate  input  2  0 = none, 1 = 90 CW, 2 = 90 CCW, 3 = 180
- indir  input  4*NUM_CH  raw {up,down,left,right} per channel; channel k at [4k+3:4k]
- outdir  output  4*NUM_CH  conditioned directions, same packing, registered
- changed  output  NUM_CH  one-clk pulse when that channel's outdir changes

Behaviour:
- Reset (async assert, sync release): outdir=0, changed=0, debounced state=0, counters=0, arbiter held direction=none.
- Debounce (per bit):
  - On ce with raw!=stable, the counter increments.
  - On ce with raw==stable, the counter clears.
  - When ce, raw!=stable and counter==2^DEB_BITS-1: stable<=raw and counter clears in that same cycle.
  - Without ce, the counter holds.
- Rotation is combinational on the stable bits:
  - CW: up<-left, right<-up, down<-right, left<-down.
  - CCW is the inverse mapping; 180 swaps up/down and left/right.
- SOCD: if up&down both set, both are cleared; same for left&right. Applied after rotation, in all modes.
- Mode 0: outdir <= SOCD result, 1 clk after the stable/rotation change.
- Mode 1 (last-pressed):
  - A rising edge on any SOCD-resolved bit makes that bit the held direction.
  - Simultaneous rises resolve by priority up>down>left>right.
  - When the held bit falls, the highest-priority still-set bit becomes held; if none is set, held=none.
  - outdir = one-hot held, or 0.
- Mode 2 (first-held):
  - Held direction persists while its bit is set; new presses are ignored.
  - On release, the highest-priority still-set bit becomes held, or none.
- Timing: edge detection compares against the previous SOCD result, registered each clk. outdir updates exactly 1 clk after the SOCD result changes.
- A change of mode or rotate (registered compare) clears all arbiter held states and edge history that cycle. The next cycle recomputes as if every currently-set bit had just risen (priority applies).
- changed[k] = 1 for one clk in the cycle outdir[k] takes a new value; it is never set while reset is asserted.
- Reset mid-debounce discards partial counts.
- ce held high continuously is legal; the debounce window is then 2^DEB_BITS clks.

Optional Feature:
- Macro: JOYDIR_SOCD_LAST_EN.
- When defined: opposing pairs resolve to the most recently risen member of the pair instead of neutral. Simultaneous rise gives neutral. When the newer member is released, the older, still-held member reappears.
- When undefined: neutral SOCD as described above.
- Debounce, rotation and arbitration are otherwise unchanged.

Test Plan:
- Debounce: DEB_BITS=2, ce every clk, ch0 indir=4'b1000 for 3 clks then 0 -> outdir stays 0. Hold 4 clks -> stable up on the 4th ce, outdir=4'b1000 one clk later, changed[0] pulses once.
- Mode 1: hold up (1000) then add right (1001) -> outdir 1000 then 0001. Release right -> 1000. Release up -> 0000. Each change gives one changed pulse.
- Mode 2: hold left (0010) then add down (0110) -> outdir stays 0010. Release left -> 0100.
- Rotation: rotate=1, mode 0, raw up -> outdir right (0001). Switch rotate to 3 while held -> outdir down (0100) after the recompute cycle.
- SOCD: mode 0, raw 1100 -> outdir 0000. With JOYDIR_SOCD_LAST_EN: up then down -> 0100; release down -> 1000.
- Reset/isolation: NUM_CH=2, ch1 active while ch0 idle -> ch0 outputs unaffected. Assert reset_n=0 mid-hold -> outdir=0 and changed=0 immediately (async). After release, output requires a full debounce window again.
